// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised synchronous FIFO built on a register array.
// Tracks occupancy in a registered level counter and derives all status flags from it.
// Keeps sticky overflow/underflow flags that are cleared by clr_err.
// Build option SYNC_FIFO_FWFT_EN: when defined, data_out shows the head word
// combinationally (first-word fall-through). When undefined, data_out is
// registered and updated on each accepted read.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_THRESH  = (2**ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come straight from the registered level.
  assign level        = level_q;
  assign full         = (level_q == DEPTH_L);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_L);
  assign almost_empty = (level_q <= AE_L);

  // A flush cycle suppresses both transfers.
  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // Pointer and occupancy bookkeeping; the pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky error flags; setting has priority over clr_err, and a flush cycle leaves them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      if (wr_en && full)     overflow <= 1'b1;
      else if (clr_err)      overflow <= 1'b0;
      if (rd_en && empty)    underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible while non-empty; zero while empty.
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  // Registered read port, loaded only on an accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        data_out <= '0;
    else if (rd_acc) data_out <= mem[rd_ptr];
  end
`endif

endmodule
